// File: rtl/tex_spi_sched_if.sv
// tex_spi_sched_if: requester handshake and texture flash pad bundle for tex_spi_sched.
// The scheduler connects through the slave modport; a requester/pad model uses master.
interface tex_spi_sched_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 8
);
  logic              i_req0;
  logic [ADDR_W-1:0] i_addr0;
  logic              o_ack0;
  logic              i_req1;
  logic [ADDR_W-1:0] i_addr1;
  logic              o_ack1;
  logic [DATA_W-1:0] o_data;
  logic              o_busy;
  logic              o_tex_csb;
  logic              o_tex_sclk;
  logic              o_tex_out0;
  logic              o_tex_oeb0;
  logic [3:0]        i_tex_in;

  modport slave (
    input  i_req0, i_addr0, i_req1, i_addr1, i_tex_in,
    output o_ack0, o_ack1, o_data, o_busy,
           o_tex_csb, o_tex_sclk, o_tex_out0, o_tex_oeb0
  );

  modport master (
    output i_req0, i_addr0, i_req1, i_addr1, i_tex_in,
    input  o_ack0, o_ack1, o_data, o_busy,
           o_tex_csb, o_tex_sclk, o_tex_out0, o_tex_oeb0
  );
endinterface

// File: rtl/tex_spi_sched.sv
// tex_spi_sched: round-robin arbiter for two texel requesters sequencing one SPI flash read per grant.
// Optional macro TEX_QUAD_EN selects quad output read (0x6B) instead of single-line fast read (0x0B).
module tex_spi_sched #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 8
) (
  input  logic           i_clk,
  input  logic           i_reset,
  tex_spi_sched_if.slave bus
);

`ifdef TEX_QUAD_EN
  localparam logic [7:0] CMD_BYTE = 8'h6B;
  localparam logic [6:0] DATA_CYC = 7'd4;
  localparam int         IN_W     = 4;
  logic [IN_W-1:0] rx_in;
  assign rx_in = bus.i_tex_in;
`else
  localparam logic [7:0] CMD_BYTE = 8'h0B;
  localparam logic [6:0] DATA_CYC = 7'd16;
  localparam int         IN_W     = 1;
  logic [IN_W-1:0] rx_in;
  logic            unused_tex_in;
  assign rx_in         = bus.i_tex_in[1];
  assign unused_tex_in = ^{bus.i_tex_in[3:2], bus.i_tex_in[0]};
`endif
  localparam int RX_W = 8 - IN_W;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DONE} state_t;

  state_t            state, state_nxt;
  logic [6:0]        cyc, cyc_nxt;
  logic              grant_ok, grant_id, last_grant, cur_id;
  logic [23:0]       addr_sel;
  logic [31:0]       shreg;
  logic [RX_W-1:0]   rx;
  logic [7:0]        rx_full;
  logic [DATA_W-1:0] data_q;
  logic              csb, sclk, out0, oeb0, ack0, ack1;

  assign rx_full = {rx, rx_in};

  // Round-robin: on a tie the requester not granted last wins.
  always_comb begin
    grant_ok  = bus.i_req0 | bus.i_req1;
    grant_id  = bus.i_req1 & (~bus.i_req0 | ~last_grant);
    addr_sel  = grant_id ? 24'(bus.i_addr1) : 24'(bus.i_addr0);
    state_nxt = state;
    cyc_nxt   = cyc + 7'd1;
    case (state)
      IDLE: begin
        cyc_nxt = '0;
        if (grant_ok) state_nxt = CMD;
      end
      CMD: if (cyc == 7'd15) begin
        state_nxt = ADDR;
        cyc_nxt   = '0;
      end
      ADDR: if (cyc == 7'd47) begin
        state_nxt = DUMMY;
        cyc_nxt   = '0;
      end
      DUMMY: if (cyc == 7'd15) begin
        state_nxt = DATA;
        cyc_nxt   = '0;
      end
      DATA: if (cyc == DATA_CYC - 7'd1) begin
        state_nxt = DONE;
        cyc_nxt   = '0;
      end
      DONE: begin
        state_nxt = IDLE;
        cyc_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cyc_nxt   = '0;
      end
    endcase
  end

  // Pins are registered one cycle behind the state; even phase cycles drive sclk low,
  // which is the only moment io0 moves and the moment pad inputs are captured.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      cyc        <= '0;
      last_grant <= 1'b1;
      cur_id     <= 1'b0;
      shreg      <= '0;
      rx         <= '0;
      data_q     <= '0;
      csb        <= 1'b1;
      sclk       <= 1'b0;
      out0       <= 1'b0;
      oeb0       <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
    end else begin
      state <= state_nxt;
      cyc   <= cyc_nxt;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      case (state)
        IDLE: if (grant_ok) begin
          cur_id     <= grant_id;
          last_grant <= grant_id;
          shreg      <= {CMD_BYTE, addr_sel};
        end
        CMD, ADDR: begin
          csb  <= 1'b0;
          oeb0 <= 1'b0;
          sclk <= cyc[0];
          if (!cyc[0]) begin
            out0  <= shreg[31];
            shreg <= {shreg[30:0], 1'b0};
          end
        end
        DUMMY: begin
          oeb0 <= 1'b1;
          sclk <= cyc[0];
        end
        DATA: begin
          sclk <= cyc[0];
          if (!cyc[0] && cyc != 7'd0) rx <= rx_full[RX_W-1:0];
        end
        DONE: begin
          csb    <= 1'b1;
          sclk   <= 1'b0;
          data_q <= DATA_W'(rx_full);
          ack0   <= ~cur_id;
          ack1   <= cur_id;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy     = (state != IDLE);
  assign bus.o_tex_csb  = csb;
  assign bus.o_tex_sclk = sclk;
  assign bus.o_tex_out0 = out0;
  assign bus.o_tex_oeb0 = oeb0;
  assign bus.o_ack0     = ack0;
  assign bus.o_ack1     = ack1;
  assign bus.o_data     = data_q;

endmodule

// File: tb/tb_tex_spi_sched.sv
// tb_tex_spi_sched: randomized and directed bench for tex_spi_sched with a flash pad model
// and a transaction-level timing reference. Honors TEX_QUAD_EN the same way as the design.
module tb_tex_spi_sched;

`ifdef TEX_QUAD_EN
  localparam int         LAT     = 85;
  localparam logic [7:0] CMD     = 8'h6B;
  localparam logic [7:0] SPECIAL = 8'hA5;
`else
  localparam int         LAT     = 97;
  localparam logic [7:0] CMD     = 8'h0B;
  localparam logic [7:0] SPECIAL = 8'h3C;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   edge_no = 0;

  tex_spi_sched_if #(.ADDR_W(24), .DATA_W(8)) bus ();

  tex_spi_sched #(.ADDR_W(24), .DATA_W(8)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: one transaction record, pin values derived from the offset since the grant edge.
  logic        m_act = 1'b0, m_last = 1'b1, m_id = 1'b0;
  int          m_n = 0, free_at = 0, exp_acks = 0, seen_acks = 0;
  logic [23:0] m_addr = '0;
  logic [31:0] m_word = '0;
  logic        m_csb = 1'b1, m_sclk = 1'b0, m_oeb = 1'b1, m_out0 = 1'b0, m_busy = 1'b0;
  logic        m_ack0 = 1'b0, m_ack1 = 1'b0;
  logic [7:0]  m_data = '0;

  // Flash pad model state
  logic        f_prev_sclk = 1'b0, f_prev_out0 = 1'b0;
  int          f_rise = 0, io0_viol = 0;
  logic [31:0] f_shift = '0;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    if (a == 24'h012345) return SPECIAL;
    return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ 8'h96;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h edge=%0d", tag, got, exp, edge_no);
    end
  endtask

  task automatic modelEdge();
    int   k;
    logic win;
    edge_no++;
    m_ack0 = 1'b0;
    m_ack1 = 1'b0;
    if (rst) begin
      m_act   = 1'b0;
      m_last  = 1'b1;
      m_out0  = 1'b0;
      m_data  = '0;
      free_at = edge_no + 1;
    end else begin
      if (m_act && (edge_no - m_n) == LAT) begin
        m_act = 1'b0;
        if (m_id) m_ack1 = 1'b1;
        else      m_ack0 = 1'b1;
        m_data = flash_byte(m_addr);
        exp_acks++;
      end
      if (!m_act && edge_no >= free_at && (bus.i_req0 || bus.i_req1)) begin
        win     = (bus.i_req0 && bus.i_req1) ? ~m_last : bus.i_req1;
        m_last  = win;
        m_id    = win;
        m_act   = 1'b1;
        m_n     = edge_no;
        m_addr  = win ? bus.i_addr1 : bus.i_addr0;
        m_word  = {CMD, m_addr};
        free_at = edge_no + LAT + 1;
      end
    end
    k      = m_act ? edge_no - m_n : -1;
    m_busy = m_act;
    m_csb  = !(m_act && k >= 1);
    m_sclk = m_act && k >= 1 && (k % 2 == 0);
    m_oeb  = !(m_act && k >= 1 && k <= 64);
    if (m_act && k >= 1 && k <= 64) m_out0 = m_word[31 - (k - 1) / 2];
  endtask

  task automatic flashUpdate();
    logic [3:0] junk;
    logic [7:0] b;
    int         j;
    junk = 4'($urandom);
    if (bus.o_tex_out0 != f_prev_out0 && bus.o_tex_sclk) io0_viol++;
    bus.i_tex_in = junk;
    if (bus.o_tex_csb) begin
      f_rise  = 0;
      f_shift = '0;
    end else if (bus.o_tex_sclk && !f_prev_sclk) begin
      f_rise++;
      if (f_rise <= 32) f_shift = {f_shift[30:0], bus.o_tex_out0};
      if (f_rise == 32 && m_act) begin
        checkOutput("wire_cmd", 32'(f_shift[31:24]), 32'(CMD));
        checkOutput("wire_addr", 32'(f_shift[23:0]), 32'(m_addr));
      end
      if (f_rise >= 41) begin
        j = f_rise - 41;
        b = flash_byte(f_shift[23:0]);
`ifdef TEX_QUAD_EN
        bus.i_tex_in = (j == 0) ? b[7:4] : b[3:0];
`else
        if (j < 8) bus.i_tex_in = {junk[3:2], b[7 - j], junk[0]};
`endif
      end
    end
    f_prev_sclk = bus.o_tex_sclk;
    f_prev_out0 = bus.o_tex_out0;
  endtask

  // One clock: apply inputs, advance the reference, then compare every pin after the edge.
  task automatic applyStimulus(input logic r0, input logic [23:0] a0,
                               input logic r1, input logic [23:0] a1, input logic rs);
    bus.i_req0  = r0;
    bus.i_addr0 = a0;
    bus.i_req1  = r1;
    bus.i_addr1 = a1;
    rst         = rs;
    modelEdge();
    @(posedge clk);
    #1;
    checkOutput("pins{csb,sclk,oeb0,out0,busy,ack0,ack1}",
                32'({bus.o_tex_csb, bus.o_tex_sclk, bus.o_tex_oeb0, bus.o_tex_out0,
                     bus.o_busy, bus.o_ack0, bus.o_ack1}),
                32'({m_csb, m_sclk, m_oeb, m_out0, m_busy, m_ack0, m_ack1}));
    checkOutput("data", 32'(bus.o_data), 32'(m_data));
    if (bus.o_ack0 || bus.o_ack1) seen_acks++;
    flashUpdate();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic        r0, r1, rs;
    logic [23:0] a0, a1;
    bus.i_req0   = 1'b0;
    bus.i_req1   = 1'b0;
    bus.i_addr0  = '0;
    bus.i_addr1  = '0;
    bus.i_tex_in = '0;

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
    idleCycles(2);

    // Single request from requester 0, dropped right after the grant edge.
    applyStimulus(1'b1, 24'h012345, 1'b0, '0, 1'b0);
    idleCycles(LAT + 4);

    // Both requesters held: grants must alternate 0,1,0,1.
    for (int i = 0; i < 4 * (LAT + 1) + 2; i++)
      applyStimulus(1'b1, 24'h000010, 1'b1, 24'h000020, 1'b0);
    idleCycles(LAT + 4);

    // Requester 1 drops its request one cycle after being granted.
    applyStimulus(1'b0, '0, 1'b1, 24'h00ABCD, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 24'h00ABCD, 1'b0);
    idleCycles(LAT + 4);

    // Reset in the middle of the address phase with the request still high.
    for (int i = 0; i <= 40; i++) applyStimulus(1'b1, 24'h012345, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 24'h012345, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 24'h012345, 1'b0, '0, 1'b0);
    idleCycles(LAT + 4);

    // Random requests, addresses and rare resets.
    r0 = 1'b0; r1 = 1'b0; a0 = '0; a1 = '0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        r0 = ~r0;
        if (r0) a0 = 24'($urandom);
      end
      if ($urandom_range(0, 19) == 0) begin
        r1 = ~r1;
        if (r1) a1 = 24'($urandom);
      end
      rs = ($urandom_range(0, 599) == 0);
      applyStimulus(r0, a0, r1, a1, rs);
    end
    idleCycles(LAT + 4);

    checkOutput("ack_count", 32'(seen_acks), 32'(exp_acks));
    checkOutput("io0_stable_while_sclk_high", 32'(io0_viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tex_spi_sched.md
# tex_spi_sched

Texture-memory read scheduler for raybox-zero's external texture SPI flash pads (o_tex_csb, o_tex_sclk, io_tex_io0, i_tex_in1..3). It arbitrates between two internal texel requesters and sequences one complete flash read transaction per granted request. It sits between the renderer's texture-lookup logic and the Caravel mprj_io pad connections in the user project wrapper.

## Interface

Parameters:
- ADDR_W, 24: flash byte-address width; always sent as 24 bits on the wire, zero-extended.
- DATA_W, 8: texel byte width returned to requesters; fixed at 8.

Ports:
- i_clk, in, 1: system clock; the only clock in the block.
- i_reset, in, 1: synchronous, active-high reset.
- i_req0, in, 1: requester 0 read request.
- i_addr0, in, ADDR_W: requester 0 byte address.
- o_ack0, out, 1: one-cycle pulse; o_data valid for requester 0.
- i_req1, in, 1: requester 1 read request.
- i_addr1, in, ADDR_W: requester 1 byte address.
- o_ack1, out, 1: one-cycle pulse; o_data valid for requester 1.
- o_data, out, DATA_W: read byte, held until the next ack.
- o_busy, out, 1: high whenever the state is not IDLE.
- o_tex_csb, out, 1: flash chip select, active low.
- o_tex_sclk, out, 1: flash SPI clock, equal to i_clk/2 while active.
- o_tex_out0, out, 1: io0 output value.
- o_tex_oeb0, out, 1: io0 pad output-enable, active low.
- i_tex_in, in, 4: sampled pad inputs {in3, in2, in1, io0}.

## Operation

- States: IDLE → CMD (8 bits) → ADDR (24 bits) → DUMMY (8 SCLK cycles) → DATA → DONE → IDLE.
- Arbitration happens in IDLE only. Priority is round-robin: the requester not granted last wins a tie. After reset, "last grant" = 1, so requester 0 wins the first tie.
- At grant: the winner's address and ID are latched. Later changes to req or addr have no effect on the transaction in flight.
- A requester that drops req before its ack still gets its transaction completed and its ack pulsed.
- Command byte: 0x6B (quad output read) with TEX_QUAD_EN; 0x0B (fast read) without. Command and address are sent MSB first on io0 with o_tex_oeb0=0.
- DUMMY and DATA phases: o_tex_oeb0=1 (io0 released).
- Data bit order is MSB first.
  - Quad: nibble 1 = i_tex_in[3:0] → o_data[7:4]; nibble 2 → o_data[3:0].
  - Single: 8 bits from i_tex_in[1].
- DONE: o_tex_csb=1, o_tex_sclk=0, o_data updated, o_ackN pulses for exactly one cycle.
- Reset values: o_tex_csb=1, o_tex_sclk=0, o_tex_out0=0, o_tex_oeb0=1, o_ack0=o_ack1=0, o_data=0, o_busy=0, state IDLE, last grant=1.
- Reset mid-transaction: all of the above apply on the next edge and no ack is issued. The aborted request is not remembered; it is re-arbitrated only if req is still high.

## Timing

- Every SPI bit takes 2 i_clk cycles, low phase then high phase.
- o_tex_out0 changes only on the edge that drives o_tex_sclk low.
- Inputs are sampled on the edge that drives o_tex_sclk from 1 to 0 (end of the high phase).
- Request sampled in IDLE at edge N; o_tex_csb goes low at N+1.
- Phase cycle counts: CMD 16 cycles, ADDR 48, DUMMY 16, DATA 4 (quad) or 16 (single).
- Ack/DONE cycle: N+85 (quad) or N+97 (single). IDLE resumes at N+86 / N+98.
- o_tex_csb is high for at least 1 cycle between transactions.
- Back-to-back pending requests: earliest next grant edge is N+86 (quad), giving one transaction per 86 cycles.

## Configuration

- TEX_QUAD_EN defined:
  - Command 0x6B.
  - 2-clock-pair quad data phase on i_tex_in[3:0].
  - Ack at N+85.
- TEX_QUAD_EN undefined:
  - Command 0x0B.
  - 8-bit serial data phase on i_tex_in[1].
  - Ack at N+97.
  - i_tex_in[3:2] and i_tex_in[0] are ignored.

## Test plan

- Reset, then single req0 at addr 0x012345 against a flash model returning 0xA5 → csb low at N+1. io0 shifts 0x6B then 0x012345 MSB first. o_data=0xA5 and a single o_ack0 pulse at N+85 (quad). o_ack1 stays 0 throughout.
- req0 and req1 asserted together and held, addrs 0x000010 / 0x000020 → grants alternate 0,1,0,1. Each ack matches its own address's byte. Grant spacing is 86 cycles.
- req1 dropped one cycle after grant → transaction completes and o_ack1 still pulses at N+85.
- i_reset asserted at cycle N+40 (mid-ADDR) → next cycle csb=1, sclk=0, oeb0=1, busy=0, no ack. With req still high, a new transaction starts from CMD.
- Built without TEX_QUAD_EN, model drives 0x3C serially on in1 → command 0x0B on the wire, o_data=0x3C, ack at N+97.
- SCLK/io0 phase check over a whole transaction → io0 never changes while sclk=1. oeb0=0 only during CMD/ADDR.
